// File: rtl/grid_step_scheduler.sv
// rtl/grid_step_scheduler.sv - ping-pong bank, grid load and per-generation row scheduler
//
// Purpose:
//   Owns the bank-select and row counters for a Game-of-Life grid stored in two
//   line-wide BRAM banks. Loads the grid row by row from the register file into
//   the display bank, computes one generation per step request by issuing rows
//   to the next-state pipeline (reading disp_bank, writing work_bank), and swaps
//   banks on the next video start-of-frame so the display never tears.
//
// Optional feature macro: GRID_STEP_WATCHDOG_EN
//   Adds a per-row watchdog (ROW_TIMEOUT cycles) and the sticky step_err output.
//
// Ports:
//   out_stream_aclk  clock
//   periph_reset     synchronous active-high reset
//   load_req/load_valid/load_ready/load_wr_en/load_addr   row load handshake + BRAM write
//   step_req/pause                                        generation request / request gate
//   calc_start/calc_row/row_done                          per-row next-state handshake
//   frame_sof                                             video start-of-frame pulse
//   disp_bank/work_bank                                   display (read) / work (write) bank
//   grid_valid/busy/gen_count                             status
//   step_err                                              sticky watchdog error (macro only)
module grid_step_scheduler #(
  parameter int Y_SIZE      = 720,
  parameter int Y_WIDTH     = 10,
  parameter int GEN_WIDTH   = 16,
  parameter int ROW_TIMEOUT = 4096
) (
  input  logic                 out_stream_aclk,
  input  logic                 periph_reset,
  input  logic                 load_req,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 load_wr_en,
  output logic [Y_WIDTH-1:0]   load_addr,
  input  logic                 step_req,
  input  logic                 pause,
  output logic                 calc_start,
  output logic [Y_WIDTH-1:0]   calc_row,
  input  logic                 row_done,
  input  logic                 frame_sof,
  output logic                 disp_bank,
  output logic                 work_bank,
  output logic                 grid_valid,
  output logic                 busy,
  output logic [GEN_WIDTH-1:0] gen_count
`ifdef GRID_STEP_WATCHDOG_EN
  ,
  output logic                 step_err
`endif
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_CALC_ISSUE = 3'd2;
  localparam logic [2:0] S_CALC_WAIT  = 3'd3;
  localparam logic [2:0] S_SWAP_WAIT  = 3'd4;

  localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(Y_SIZE - 1);

  if (((1 << Y_WIDTH) < Y_SIZE) || (ROW_TIMEOUT < 1)) begin : g_param_check
    $error("grid_step_scheduler: Y_WIDTH too small for Y_SIZE or ROW_TIMEOUT < 1");
  end

  logic [2:0]         state;
  logic [Y_WIDTH-1:0] load_row;
  logic               pending;

`ifdef GRID_STEP_WATCHDOG_EN
  // wd_cnt holds the number of cycles elapsed since the last calc_start.
  localparam int               WD_W     = $clog2(ROW_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(ROW_TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  assign load_ready = (state == S_LOAD);
  assign load_wr_en = load_ready && load_valid;
  assign load_addr  = load_row;
  assign calc_start = (state == S_CALC_ISSUE);
  assign busy       = (state != S_IDLE);
  assign work_bank  = ~disp_bank;

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state      <= S_IDLE;
      load_row   <= '0;
      calc_row   <= '0;
      pending    <= 1'b0;
      disp_bank  <= 1'b0;
      grid_valid <= 1'b0;
      gen_count  <= '0;
`ifdef GRID_STEP_WATCHDOG_EN
      wd_cnt     <= '0;
      step_err   <= 1'b0;
`endif
    end else begin
      // Single-deep request latch; only requests arriving while busy are held.
      if (pause) begin
        pending <= 1'b0;
      end else if (busy && step_req) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (load_req) begin
            // The display bank is about to be overwritten, so the old grid is gone.
            state      <= S_LOAD;
            load_row   <= '0;
            grid_valid <= 1'b0;
          end else if ((pending || step_req) && grid_valid && !pause) begin
            state    <= S_CALC_ISSUE;
            calc_row <= '0;
            pending  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            load_row <= load_row + 1'b1;
          end
          if (load_valid && (load_row == LAST_ROW)) begin
            grid_valid <= 1'b1;
            state      <= S_IDLE;
          end else if (!load_req) begin
            state <= S_IDLE;
          end
        end
        S_CALC_ISSUE: begin
          state <= S_CALC_WAIT;
`ifdef GRID_STEP_WATCHDOG_EN
          wd_cnt <= WD_W'(1);
`endif
        end
        S_CALC_WAIT: begin
          if (row_done) begin
            if (calc_row == LAST_ROW) begin
              state <= S_SWAP_WAIT;
            end else begin
              calc_row <= calc_row + 1'b1;
              state    <= S_CALC_ISSUE;
            end
`ifdef GRID_STEP_WATCHDOG_EN
          end else if (wd_cnt >= WD_LIMIT) begin
            // Abandon the generation: banks and generation count stay as they were.
            step_err <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        S_SWAP_WAIT: begin
          // Bank toggle and generation count move together on the frame boundary.
          if (frame_sof) begin
            disp_bank <= ~disp_bank;
            gen_count <= gen_count + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_step_scheduler.sv
// tb/tb_grid_step_scheduler.sv - randomized self-checking bench for grid_step_scheduler
module tb_grid_step_scheduler;

  localparam int Y = 720;
`ifdef GRID_STEP_WATCHDOG_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 4096;
`endif

  logic        clk;
  logic        periph_reset, load_req, load_valid, step_req, pause, row_done, frame_sof;
  logic        load_ready, load_wr_en, calc_start, disp_bank, work_bank, grid_valid, busy;
  logic [9:0]  load_addr, calc_row;
  logic [15:0] gen_count;
`ifdef GRID_STEP_WATCHDOG_EN
  logic        step_err;
`endif

  grid_step_scheduler #(
    .Y_SIZE(Y), .Y_WIDTH(10), .GEN_WIDTH(16), .ROW_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .out_stream_aclk(clk),
    .periph_reset(periph_reset),
    .load_req(load_req),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_wr_en(load_wr_en),
    .load_addr(load_addr),
    .step_req(step_req),
    .pause(pause),
    .calc_start(calc_start),
    .calc_row(calc_row),
    .row_done(row_done),
    .frame_sof(frame_sof),
    .disp_bank(disp_bank),
    .work_bank(work_bank),
    .grid_valid(grid_valid),
    .busy(busy),
    .gen_count(gen_count)
`ifdef GRID_STEP_WATCHDOG_EN
    ,
    .step_err(step_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the scheduler's activity described as a mode plus counters.
  localparam int M_IDLE = 0, M_LOAD = 1, M_ISSUE = 2, M_WAIT = 3, M_SWAP = 4;
  int m_mode = M_IDLE, m_lrow = 0, m_crow = 0, m_gen = 0, m_since = 0;
  bit m_disp = 0, m_valid = 0, m_pend = 0, m_err = 0;
  bit m_was_busy;

  always @(posedge clk) begin
    if (periph_reset) begin
      m_mode = M_IDLE; m_lrow = 0; m_crow = 0; m_gen = 0; m_since = 0;
      m_disp = 0; m_valid = 0; m_pend = 0; m_err = 0;
    end else begin
      m_was_busy = (m_mode != M_IDLE);
      if (pause) m_pend = 0;
      else if (m_was_busy && step_req) m_pend = 1;
      case (m_mode)
        M_IDLE: begin
          if (load_req) begin
            m_mode = M_LOAD; m_lrow = 0; m_valid = 0;
          end else if ((m_pend || step_req) && m_valid && !pause) begin
            m_mode = M_ISSUE; m_crow = 0; m_pend = 0;
          end
        end
        M_LOAD: begin
          if (load_valid && m_lrow == Y - 1) begin
            m_valid = 1; m_mode = M_IDLE;
          end else if (!load_req) begin
            m_mode = M_IDLE;
          end
          if (load_valid) m_lrow = (m_lrow + 1) % 1024;
        end
        M_ISSUE: begin
          m_mode = M_WAIT; m_since = 1;
        end
        M_WAIT: begin
          if (row_done) begin
            if (m_crow == Y - 1) m_mode = M_SWAP;
            else begin m_crow = m_crow + 1; m_mode = M_ISSUE; end
          end else begin
`ifdef GRID_STEP_WATCHDOG_EN
            m_since = m_since + 1;
            if (m_since == TB_TIMEOUT) begin m_err = 1; m_mode = M_IDLE; end
`endif
          end
        end
        M_SWAP: begin
          if (frame_sof) begin
            m_disp = ~m_disp; m_gen = (m_gen + 1) % 65536; m_mode = M_IDLE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping for literal checks.
  bit chk_en = 0;
  int wr_count = 0, wr_bad = 0, cs_count = 0, cs_bad = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("load_ready", load_ready, m_mode == M_LOAD);
      check("load_wr_en", load_wr_en, (m_mode == M_LOAD) && load_valid);
      check("load_addr", load_addr, m_lrow);
      check("calc_start", calc_start, m_mode == M_ISSUE);
      check("calc_row", calc_row, m_crow);
      check("disp_bank", disp_bank, m_disp);
      check("work_bank", work_bank, !m_disp);
      check("grid_valid", grid_valid, m_valid);
      check("busy", busy, m_mode != M_IDLE);
      check("gen_count", gen_count, m_gen);
`ifdef GRID_STEP_WATCHDOG_EN
      check("step_err", step_err, m_err);
`endif
    end
    if (load_wr_en) begin
      if (int'(load_addr) != wr_count) wr_bad++;
      wr_count++;
    end
    if (calc_start) begin
      if (int'(calc_row) != cs_count) cs_bad++;
      cs_count++;
    end
  end

  // Row_done responder: fixed or random latency after calc_start, optional stray pulses.
  int rd_delay = 3;
  int rd_cnt = 0;
  bit spurious_en = 0;

  always @(posedge clk) begin
    #1;
    row_done = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) row_done = 1'b1;
    end
    if (calc_start && rd_delay != 0) begin
      rd_cnt = (rd_delay < 0) ? int'($urandom_range(1, 4)) : rd_delay;
    end else if (spurious_en && rd_cnt == 0 && $urandom_range(0, 15) == 0) begin
      row_done = 1'b1;
    end
  end

  // Start-of-frame every 200 cycles.
  int sof_cnt = 0;
  always @(posedge clk) begin
    #1;
    sof_cnt = (sof_cnt + 1) % 200;
    frame_sof = (sof_cnt == 0);
  end

  task automatic do_load(input string name);
    int got = 0;
    int guard = 0;
    load_req = 1'b1;
    while (got < Y && guard < 20000) begin
      tick();
      guard++;
      load_valid = ($urandom_range(0, 3) != 0);
      if (load_valid && load_ready) begin
        got++;
        if (got == Y) load_req = 1'b0;
      end
    end
    tick();
    load_valid = 1'b0;
    load_req = 1'b0;
    check({name, "_rows_accepted"}, got, Y);
  endtask

  task automatic wait_gen(input int g, input string name);
    int n = 0;
    while (int'(gen_count) != g && n < 20000) begin tick(); n++; end
    check(name, gen_count, g);
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int lr_hold;
    periph_reset = 1; load_req = 0; load_valid = 0; step_req = 0; pause = 0;
    row_done = 0; frame_sof = 0;
    tick();
    chk_en = 1;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_grid_valid", grid_valid, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_calc_start", calc_start, 0);
    periph_reset = 0;
    tick();

    // Step before any grid is loaded is dropped.
    pulse_step();
    repeat (3) tick();
    check("drop_no_grid_busy", busy, 0);

    // Full load.
    wr_count = 0; wr_bad = 0;
    do_load("load1");
    tick();
    check("load_wr_count", wr_count, Y);
    check("load_addr_seq_errors", wr_bad, 0);
    check("load_grid_valid", grid_valid, 1);
    check("load_disp_bank", disp_bank, 0);
    check("load_busy", busy, 0);

    // One generation with row_done 3 cycles after each calc_start.
    cs_count = 0; cs_bad = 0;
    pulse_step();
    wait_gen(1, "step_gen1");
    check("step_calc_starts", cs_count, Y);
    check("step_calc_row_seq_errors", cs_bad, 0);
    check("step_disp_bank", disp_bank, 1);

    // Pending collapse and load priority.
    pulse_step();
    repeat (5) tick();
    pulse_step();
    repeat (5) tick();
    pulse_step();
    wr_count = 0; wr_bad = 0;
    do_load("load2");
    check("prio_gen_after_load", gen_count, 2);
    check("prio_wr_count", wr_count, Y);
    wait_gen(3, "prio_gen3");
    repeat (300) tick();
    check("prio_single_extra_gen", gen_count, 3);
    check("prio_idle", busy, 0);

    // Pause blocks and discards step requests.
    pause = 1;
    repeat (3) begin pulse_step(); tick(); end
    repeat (10) tick();
    check("pause_busy", busy, 0);
    check("pause_gen", gen_count, 3);
    pause = 0;
    repeat (5) tick();
    check("pause_release_busy", busy, 0);

    // Reset in the middle of a generation.
    pulse_step();
    n = 0;
    while (!(calc_start && calc_row == 10'd300) && n < 5000) begin tick(); n++; end
    check("reach_row_300", calc_row, 300);
    periph_reset = 1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_disp_bank", disp_bank, 0);
    check("midrst_gen_count", gen_count, 0);
    check("midrst_grid_valid", grid_valid, 0);
    check("midrst_calc_start", calc_start, 0);
    periph_reset = 0;
    tick();

    do_load("load3");

`ifdef GRID_STEP_WATCHDOG_EN
    rd_delay = 0;
    repeat (10) tick();
    pulse_step();
    n = 0;
    while (!calc_start && n < 10) begin tick(); n++; end
    check("wd_calc_start", calc_start, 1);
    n = 0;
    while (!step_err && n < 100) begin tick(); n++; end
    check("wd_err_latency", n, 16);
    check("wd_busy", busy, 0);
    check("wd_gen_unchanged", gen_count, 0);
    rd_delay = 3;
`endif

    // Randomized phase; the model checks every cycle.
    rd_delay = -1;
    spurious_en = 1;
    lr_hold = 0;
    for (int c = 0; c < 12000; c++) begin
      tick();
      step_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) pause = ~pause;
      if (lr_hold > 0) begin
        lr_hold--;
        if (lr_hold == 0) load_req = 0;
      end else if ($urandom_range(0, 2999) == 0) begin
        load_req = 1;
        lr_hold = int'($urandom_range(50, 1400));
      end
      load_valid = ($urandom_range(0, 3) != 0);
      periph_reset = ($urandom_range(0, 4999) == 0);
    end
    step_req = 0; pause = 0; load_req = 0; load_valid = 0; periph_reset = 0;
    spurious_en = 0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
